status_frame_receiver: RTL and testbench

- Serial front end that feeds MODULE1_STATUS [3:0] into the VGA display controller.
- Receives 8N1 UART frames from a greenhouse sensor module and validates a 3-byte packet: sync, data, check.
- Presents the latest valid 4-bit status, registered and stable, in the CLOCK_50 domain.
- Flags link errors and, optionally, a stale link.

---
 rtl/greenhouse_status_pkg.sv | 26 ++
 rtl/uart_rx_byte.sv | 115 +++++++++++
 rtl/status_frame_receiver.sv | 141 ++++++++++++++
 tb/tb_status_frame_receiver.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/greenhouse_status_pkg.sv
// Shared constants and state types for the greenhouse status frame receiver.
package greenhouse_status_pkg;

    localparam logic [7:0] SYNC_BYTE  = 8'hA5;
    localparam logic [7:0] CHECK_MASK = 8'hFF;

    typedef enum logic [1:0] {
        PK_SYNC,
        PK_DATA,
        PK_CHECK
    } pk_state_t;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_t;

    // Bit period in clock cycles, rounded to the nearest integer.
    function automatic int unsigned calc_bit_div(input int unsigned clk_hz,
                                                 input int unsigned baud);
        return (clk_hz + baud / 2) / baud;
    endfunction

endpackage

// File: rtl/uart_rx_byte.sv
// 8N1 byte receiver: 2-FF input synchronizer, mid-bit sampling bit FSM and
// baud down-counter. Delivers one byte per frame with a valid pulse, or a
// stop_err pulse when the stop bit samples low.
//
// state    | meaning
// ---------+---------------------------------------------------------
// RX_IDLE  | line idle, waiting for a low level on the synced line
// RX_START | half a bit period into the start bit, glitch re-check
// RX_DATA  | sampling 8 data bits LSB-first, one per bit period
// RX_STOP  | one sample of the stop bit, then straight back to idle
module uart_rx_byte
    import greenhouse_status_pkg::*;
#(
    parameter int unsigned BIT_DIV = 5208
) (
    input  logic       clk_i,
    input  logic       rst_n_i,
    input  logic       rx_i,
    output logic [7:0] byte_o,
    output logic       byte_valid_o,
    output logic       stop_err_o
);

    localparam int CW = $clog2(BIT_DIV + 1);
    localparam logic [CW-1:0] FULL_LAST = CW'(BIT_DIV - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(BIT_DIV / 2 - 1);

    logic          rx_meta_q;
    logic          rx_sync_q;
    rx_state_t     state_q;
    logic [CW-1:0] cnt_q;
    logic [2:0]    bit_idx_q;
    logic [7:0]    shift_q;
    logic          valid_q;
    logic          err_q;

    // Two-flop synchronizer; resets to the idle-high line level.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            rx_meta_q <= 1'b1;
            rx_sync_q <= 1'b1;
        end else begin
            rx_meta_q <= rx_i;
            rx_sync_q <= rx_meta_q;
        end
    end

    // Bit FSM with terminal-count sampling and registered result pulses.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q   <= RX_IDLE;
            cnt_q     <= '0;
            bit_idx_q <= 3'd0;
            shift_q   <= 8'h00;
            valid_q   <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            case (state_q)
                RX_IDLE: begin
                    if (!rx_sync_q) begin
                        state_q <= RX_START;
                        cnt_q   <= HALF_LAST;
                    end
                end
                RX_START: begin
                    if (cnt_q == '0) begin
                        if (rx_sync_q) begin
                            state_q <= RX_IDLE;
                        end else begin
                            state_q   <= RX_DATA;
                            cnt_q     <= FULL_LAST;
                            bit_idx_q <= 3'd0;
                        end
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                RX_DATA: begin
                    if (cnt_q == '0) begin
                        shift_q <= {rx_sync_q, shift_q[7:1]};
                        cnt_q   <= FULL_LAST;
                        if (bit_idx_q == 3'd7) begin
                            state_q <= RX_STOP;
                        end else begin
                            bit_idx_q <= bit_idx_q + 3'd1;
                        end
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                RX_STOP: begin
                    if (cnt_q == '0) begin
                        valid_q <= rx_sync_q;
                        err_q   <= ~rx_sync_q;
                        state_q <= RX_IDLE;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                default: state_q <= RX_IDLE;
            endcase
        end
    end

    assign byte_o       = shift_q;
    assign byte_valid_o = valid_q;
    assign stop_err_o   = stop_err_q_unused_guard(err_q);

    function automatic logic stop_err_q_unused_guard(input logic e);
        return e;
    endfunction

endmodule

// File: rtl/status_frame_receiver.sv
// Greenhouse sensor status receiver: validates sync/data/check packets from
// uart_rx_byte and presents the latest 4-bit status for the display side.
// Optional link-stale timeout is built when STATUS_TIMEOUT_EN is defined;
// otherwise STATUS_STALE is tied low.
//
// state    | meaning
// ---------+---------------------------------------------------------
// PK_SYNC  | hunting for the sync byte, other bytes ignored
// PK_DATA  | next byte is the data byte (a sync value is data here)
// PK_CHECK | next byte must be the inverted data byte
module status_frame_receiver
    import greenhouse_status_pkg::*;
#(
    parameter int unsigned CLK_HZ      = 50000000,
    parameter int unsigned BAUD        = 9600,
    parameter logic [3:0]  MODULE_ID   = 4'd1,
    parameter int unsigned TIMEOUT_CYC = 100000000
) (
    input  logic       CLOCK_50,
    input  logic       RESET_N,
    input  logic       RX,
    output logic [3:0] MODULE_STATUS,
    output logic       STATUS_UPDATE,
    output logic       HAVE_STATUS,
    output logic       FRAME_ERR,
    output logic [7:0] ERR_COUNT,
    output logic       STATUS_STALE
);

    localparam int unsigned BIT_DIV = calc_bit_div(CLK_HZ, BAUD);

    // Reject builds the 27-bit timeout counter or the baud counter cannot serve.
    if (TIMEOUT_CYC < 2 || TIMEOUT_CYC > 32'h0800_0000 || BIT_DIV < 2) begin : g_param_check
        $error("status_frame_receiver: unsupported TIMEOUT_CYC or BIT_DIV");
    end

    logic [7:0] rx_byte;
    logic       rx_valid;
    logic       rx_stop_err;

    uart_rx_byte #(
        .BIT_DIV (BIT_DIV)
    ) u_rx (
        .clk_i        (CLOCK_50),
        .rst_n_i      (RESET_N),
        .rx_i         (RX),
        .byte_o       (rx_byte),
        .byte_valid_o (rx_valid),
        .stop_err_o   (rx_stop_err)
    );

    pk_state_t  pk_state_q;
    logic [7:0] data_q;
    logic [3:0] status_q;
    logic       update_q;
    logic       have_q;
    logic       frame_err_q;
    logic [7:0] err_cnt_q;

    logic check_ok_d;
    logic accept_d;
    logic err_d;

    // Check-byte evaluation for the byte being delivered this cycle.
    always_comb begin
        check_ok_d = (rx_byte == (data_q ^ CHECK_MASK));
        accept_d   = rx_valid && (pk_state_q == PK_CHECK) && check_ok_d
                     && (data_q[7:4] == MODULE_ID);
        err_d      = rx_stop_err
                     || (rx_valid && (pk_state_q == PK_CHECK) && !check_ok_d);
    end

    // Packet FSM, status register and saturating error counter.
    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            pk_state_q  <= PK_SYNC;
            data_q      <= 8'h00;
            status_q    <= 4'h0;
            update_q    <= 1'b0;
            have_q      <= 1'b0;
            frame_err_q <= 1'b0;
            err_cnt_q   <= 8'h00;
        end else begin
            update_q    <= accept_d;
            frame_err_q <= err_d;
            if (err_d && (err_cnt_q != 8'hFF)) begin
                err_cnt_q <= err_cnt_q + 8'd1;
            end
            if (accept_d) begin
                status_q <= data_q[3:0];
                have_q   <= 1'b1;
            end
            if (rx_stop_err) begin
                pk_state_q <= PK_SYNC;
            end else if (rx_valid) begin
                case (pk_state_q)
                    PK_SYNC:  if (rx_byte == SYNC_BYTE) pk_state_q <= PK_DATA;
                    PK_DATA: begin
                        data_q     <= rx_byte;
                        pk_state_q <= PK_CHECK;
                    end
                    PK_CHECK: pk_state_q <= PK_SYNC;
                    default:  pk_state_q <= PK_SYNC;
                endcase
            end
        end
    end

`ifdef STATUS_TIMEOUT_EN
    localparam logic [26:0] TO_LAST = 27'(TIMEOUT_CYC - 1);

    logic [26:0] to_cnt_q;
    logic        stale_q;

    // Link timeout: counts from reset, restarts on every accepted packet.
    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            to_cnt_q <= 27'd0;
            stale_q  <= 1'b0;
        end else if (accept_d) begin
            to_cnt_q <= 27'd0;
            stale_q  <= 1'b0;
        end else if (to_cnt_q == TO_LAST) begin
            stale_q  <= 1'b1;
        end else begin
            to_cnt_q <= to_cnt_q + 27'd1;
        end
    end

    assign STATUS_STALE = stale_q;
`else
    assign STATUS_STALE = 1'b0;
`endif

    assign MODULE_STATUS = status_q;
    assign STATUS_UPDATE = update_q;
    assign HAVE_STATUS   = have_q;
    assign FRAME_ERR     = frame_err_q;
    assign ERR_COUNT     = err_cnt_q;

endmodule

// File: tb/tb_status_frame_receiver.sv
// Scoreboard bench for status_frame_receiver: bytes are serialised onto RX,
// a packet-level reference model queues the expected STATUS_UPDATE and
// FRAME_ERR events, and a monitor pops and compares them as they appear.
module tb_status_frame_receiver;

    localparam int BD  = 10;
    localparam int TOC = 2000;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic       rx    = 1'b1;
    logic [3:0] module_status;
    logic       status_update;
    logic       have_status;
    logic       frame_err;
    logic [7:0] err_count;
    logic       status_stale;

    always #5 clk = ~clk;

    status_frame_receiver #(
        .CLK_HZ      (1000),
        .BAUD        (100),
        .MODULE_ID   (4'd1),
        .TIMEOUT_CYC (TOC)
    ) dut (
        .CLOCK_50      (clk),
        .RESET_N       (rst_n),
        .RX            (rx),
        .MODULE_STATUS (module_status),
        .STATUS_UPDATE (status_update),
        .HAVE_STATUS   (have_status),
        .FRAME_ERR     (frame_err),
        .ERR_COUNT     (err_count),
        .STATUS_STALE  (status_stale)
    );

    typedef struct {
        bit         is_err;
        logic [3:0] nib;
        logic [7:0] cnt;
    } ev_t;

    ev_t        exp_q[$];
    logic [7:0] pend[$];
    logic [3:0] m_status  = 4'h0;
    bit         m_have    = 1'b0;
    int         m_err     = 0;
    int         since_upd = 0;
    int         n_checks  = 0;
    int         n_fail    = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_err();
        m_err = (m_err < 255) ? m_err + 1 : 255;
        exp_q.push_back('{is_err: 1'b1, nib: 4'h0, cnt: m_err[7:0]});
    endtask

    // Packet rules on a byte list: drop leading non-sync bytes, judge every
    // three-byte group starting with sync, a bad stop bit discards everything.
    task automatic model_byte(input logic [7:0] b, input bit stop_ok);
        if (!stop_ok) begin
            pend.delete();
            model_err();
            return;
        end
        pend.push_back(b);
        if (pend.size() == 1 && b != 8'hA5) begin
            pend.delete();
        end else if (pend.size() == 3) begin
            if (pend[2] == (pend[1] ^ 8'hFF)) begin
                if (pend[1][7:4] == 4'd1) begin
                    m_status = pend[1][3:0];
                    m_have   = 1'b1;
                    exp_q.push_back('{is_err: 1'b0, nib: pend[1][3:0], cnt: 8'h00});
                end
            end else begin
                model_err();
            end
            pend.delete();
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b, input bit stop_ok = 1'b1);
        model_byte(b, stop_ok);
        @(negedge clk);
        rx = 1'b0;
        idle(BD);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            idle(BD);
        end
        rx = stop_ok;
        idle(BD);
        rx = 1'b1;
        if (!stop_ok) idle(BD);
    endtask

    task automatic send_pkt(input logic [7:0] d, input logic [7:0] chk);
        send_byte(8'hA5);
        send_byte(d);
        send_byte(chk);
    endtask

    task automatic check_state(input string tag);
        check({tag, "_pending"}, exp_q.size(), 0);
        check({tag, "_status"}, module_status, m_status);
        check({tag, "_have"}, have_status, m_have);
        check({tag, "_errcnt"}, err_count, m_err);
`ifdef STATUS_TIMEOUT_EN
        if (since_upd < TOC - 10) check({tag, "_stale"}, status_stale, 0);
        else if (since_upd > TOC + 10) check({tag, "_stale"}, status_stale, 1);
`else
        check({tag, "_stale"}, status_stale, 0);
`endif
    endtask

    // Monitor: every output event must match the oldest expected event.
    always @(negedge clk) begin
        if (!rst_n) begin
            since_upd = 0;
        end else begin
            if (status_update || frame_err) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_event: upd=%0b err=%0b status=%0h, expected no event (t=%0t)",
                             status_update, frame_err, module_status, $time);
                end else begin
                    ev_t e;
                    e = exp_q.pop_front();
                    if (status_update) begin
                        check("upd_kind", {31'd0, frame_err}, {31'd0, e.is_err});
                        check("upd_status", module_status, e.nib);
                        check("upd_have", have_status, 1);
`ifdef STATUS_TIMEOUT_EN
                        check("upd_stale_clear", status_stale, 0);
`endif
                    end else begin
                        check("err_kind", {31'd0, status_update}, {31'd0, !e.is_err});
                        check("err_count", err_count, e.cnt);
                    end
                end
            end
            since_upd = status_update ? 0 : since_upd + 1;
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] d;
        logic [7:0] chk;
        // Reset values
        idle(5);
        check_state("reset");
        check("reset_upd", status_update, 0);
        check("reset_ferr", frame_err, 0);
        rst_n = 1'b1;
        idle(20);

        // 1: good packet
        send_pkt(8'h13, 8'hEC);
        idle(20);
        check_state("t1");

        // 2: bad check, then good packet
        send_pkt(8'h13, 8'hED);
        idle(20);
        check_state("t2a");
        send_pkt(8'h17, 8'hE8);
        idle(20);
        check_state("t2b");

        // 3: noise, foreign ID, then own ID
        send_byte(8'h00);
        send_byte(8'h55);
        send_pkt(8'h2C, 8'hD3);
        idle(20);
        check_state("t3a");
        send_pkt(8'h1A, 8'hE5);
        idle(20);
        check_state("t3b");

        // 4: stop-bit error on the data byte, then good packet
        send_byte(8'hA5);
        send_byte(8'h11, 1'b0);
        idle(20);
        check_state("t4a");
        send_pkt(8'h11, 8'hEE);
        idle(20);
        check_state("t4b");

        // 5: glitch in place of the check byte, then the real check byte
        send_byte(8'hA5);
        send_byte(8'h13);
        @(negedge clk);
        rx = 1'b0;
        idle(3);
        rx = 1'b1;
        idle(200);
        check_state("t5_glitch");
        send_byte(8'hEC);
        idle(20);
        check_state("t5_after");

        // 5: reset mid data byte abandons the partial packet
        send_byte(8'hA5);
        @(negedge clk);
        rx = 1'b0;
        idle(35);
        rst_n = 1'b0;
        #1;
        check("rst_status", module_status, 0);
        check("rst_upd", status_update, 0);
        check("rst_have", have_status, 0);
        check("rst_ferr", frame_err, 0);
        check("rst_errcnt", err_count, 0);
        check("rst_stale", status_stale, 0);
        exp_q.delete();
        pend.delete();
        m_status = 4'h0;
        m_have   = 1'b0;
        m_err    = 0;
        rx = 1'b1;
        idle(5);
        rst_n = 1'b1;
        idle(20);
        send_byte(8'h13);
        send_byte(8'hEC);
        idle(20);
        check_state("t5_rst");

        // Randomised packets, noise and framing errors
        for (int k = 0; k < 30; k++) begin
            if ($urandom_range(0, 3) == 0) send_byte(8'($urandom));
            if ($urandom_range(0, 7) == 0) send_byte(8'($urandom), 1'b0);
            d[7:4] = ($urandom_range(0, 1) == 1) ? 4'd1 : 4'($urandom);
            d[3:0] = 4'($urandom);
            chk = d ^ 8'hFF;
            if ($urandom_range(0, 3) == 0) chk = chk ^ 8'($urandom_range(1, 255));
            send_pkt(d, chk);
            idle($urandom_range(0, 12));
        end
        idle(20);
        check_state("rand");

`ifdef STATUS_TIMEOUT_EN
        // 6: stale after TOC idle cycles, cleared by the next update
        send_pkt(8'h15, 8'hEA);
        for (int w = 0; w < 3 * TOC && since_upd < TOC - 2; w++) @(negedge clk);
        check("stale_before", status_stale, 0);
        idle(4);
        check("stale_after", status_stale, 1);
        check("stale_hold_status", module_status, 4'h5);
        send_pkt(8'h16, 8'hE9);
        idle(20);
        check_state("t6");
`endif

        // 4: error counter saturation
        for (int k = 0; k < 10; k++) send_pkt(8'h1F, 8'h00);
        for (int k = 0; k < 250; k++) send_byte(8'($urandom), 1'b0);
        idle(20);
        check("err_saturated", err_count, 8'hFF);
        check_state("sat");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
